keypad_decoder: RTL and testbench

KEYPAD_DECODER -- requirements
Module: keypad_decoder

---
 rtl/keypad_decoder_pkg.sv | 49 ++++
 rtl/keypad_event_fifo.sv | 61 ++++++
 rtl/keypad_decoder.sv | 109 ++++++++++
 tb/tb_keypad_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_decoder_pkg.sv
// Shared definitions for the PS/2 keypad decoder: FSM states, prefix codes
// and the scan-code-to-key-index table.
package keypad_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kbd_state_e;

   localparam logic [7:0] CODE_BRK     = 8'hF0;
   localparam logic [7:0] CODE_EXT     = 8'hE0;
   localparam logic [7:0] CODE_BAT_OK  = 8'hAA;
   localparam logic [7:0] CODE_BAT_ERR = 8'hFC;

   localparam int TABLE_SIZE = 16;

   // Entry i holds the set-2 scan code that maps to key index i.
   localparam logic [7:0] KEY_CODE_TABLE [TABLE_SIZE] = '{
      8'h22, 8'h16, 8'h1E, 8'h26,
      8'h15, 8'h1D, 8'h24, 8'h1C,
      8'h1B, 8'h23, 8'h1A, 8'h21,
      8'h25, 8'h2D, 8'h2B, 8'h2A
   };

   typedef struct packed {
      logic       hit;
      logic [4:0] idx;
   } key_lookup_t;

   function automatic key_lookup_t map_code(input logic [7:0] scan);
      key_lookup_t res;
      res = '0;
      for (int i = 0; i < TABLE_SIZE; i++) begin
         if (!res.hit && KEY_CODE_TABLE[i] == scan) begin
            res.hit = 1'b1;
            res.idx = 5'(i);
         end
      end
      return res;
   endfunction

   function automatic logic is_prefix(input logic [7:0] scan);
      return (scan == CODE_BRK) || (scan == CODE_EXT) ||
             (scan == CODE_BAT_OK) || (scan == CODE_BAT_ERR);
   endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Small synchronous FIFO for key events; a push on a full FIFO succeeds
// only when a pop happens in the same cycle, otherwise it is dropped.
module keypad_event_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       res,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       valid,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             pop_ok;
   logic             push_ok;

   assign full    = (count == CW'(DEPTH));
   assign valid   = (count != '0);
   assign pop_ok  = pop && valid && !flush;
   assign push_ok = push && !flush && (!full || pop_ok);
   assign dropped = push && !flush && full && !pop_ok;
   assign head    = valid ? mem[rd_ptr] : '0;

   // Pointers are power-of-two wide, so natural overflow wraps them.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/keypad_decoder.sv
// PS/2 set-2 keypad decoder: key-held matrix plus a press/release event FIFO.
// Optional KEYPAD_TYPEMATIC_FILTER_EN suppresses events that do not change the matrix.
//
// state      | meaning
// ST_IDLE    | waiting for a make code or a prefix byte
// ST_BRK     | F0 seen, next byte is a break
// ST_EXT     | E0 seen, extended code (ignored unless F0 follows)
// ST_EXT_BRK | E0 F0 seen, next byte is an ignored extended break
module keypad_decoder
   import keypad_decoder_pkg::*;
#(
   parameter int NUM_KEYS   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                res,
   input  logic                code_valid,
   input  logic [7:0]          code,
   input  logic                clear,
   output logic [NUM_KEYS-1:0] key_matrix,
   output logic                any_key,
   output logic                evt_valid,
   output logic [4:0]          evt_key,
   output logic                evt_down,
   input  logic                evt_ready,
   output logic                overflow
);

   localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);

   kbd_state_e                 state;
   key_lookup_t                lookup;
   logic                       hit;
   logic [NUM_KEYS-1:0]        key_bit;
   logic                       is_make;
   logic                       is_break;
   logic                       clr_matrix;
   logic                       evt_push;
   logic [5:0]                 fifo_head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                       fifo_dropped;

   always_comb begin
      lookup     = map_code(code);
      hit        = lookup.hit && (32'(lookup.idx) < NUM_KEYS);
      key_bit    = hit ? (KEY_ONE << lookup.idx) : '0;
      is_make    = code_valid && (state == ST_IDLE) && !is_prefix(code);
      is_break   = code_valid && (state == ST_BRK);
      clr_matrix = code_valid && (state == ST_IDLE) &&
                   ((code == CODE_BAT_OK) || (code == CODE_BAT_ERR));
`ifdef KEYPAD_TYPEMATIC_FILTER_EN
      // Only report real transitions: auto-repeat makes and stray breaks are silent.
      evt_push   = hit && ((is_make && !(|(key_matrix & key_bit))) ||
                           (is_break && (|(key_matrix & key_bit))));
`else
      evt_push   = hit && (is_make || is_break);
`endif
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state      <= ST_IDLE;
         key_matrix <= '0;
         overflow   <= 1'b0;
      end else if (clear) begin
         state      <= ST_IDLE;
         key_matrix <= '0;
         overflow   <= 1'b0;
      end else begin
         if (code_valid) begin
            case (state)
               ST_IDLE: begin
                  if (code == CODE_BRK)      state <= ST_BRK;
                  else if (code == CODE_EXT) state <= ST_EXT;
                  else                       state <= ST_IDLE;
               end
               ST_EXT:  state <= (code == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
         if (clr_matrix)    key_matrix <= '0;
         else if (is_make)  key_matrix <= key_matrix | key_bit;
         else if (is_break) key_matrix <= key_matrix & ~key_bit;
         if (fifo_dropped) overflow <= 1'b1;
      end
   end

   assign any_key = |key_matrix;

   keypad_event_fifo #(
      .WIDTH (6),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .res       (res),
      .flush     (clear),
      .push      (evt_push),
      .push_data ({lookup.idx, is_make}),
      .pop       (evt_ready),
      .valid     (evt_valid),
      .head      (fifo_head),
      .count     (fifo_count),
      .dropped   (fifo_dropped)
   );

   assign evt_key  = fifo_head[5:1];
   assign evt_down = fifo_head[0];

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed self-checking bench for keypad_decoder (default 16 keys, 4-deep FIFO).
module tb_keypad_decoder;
   import keypad_decoder_pkg::*;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        code_valid = 1'b0;
   logic [7:0]  code = 8'h00;
   logic        clear = 1'b0;
   logic [15:0] key_matrix;
   logic        any_key;
   logic        evt_valid;
   logic [4:0]  evt_key;
   logic        evt_down;
   logic        evt_ready = 1'b0;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   keypad_decoder #(.NUM_KEYS(16), .FIFO_DEPTH(4)) u_dut (
      .clk        (clk),
      .res        (res),
      .code_valid (code_valid),
      .code       (code),
      .clear      (clear),
      .key_matrix (key_matrix),
      .any_key    (any_key),
      .evt_valid  (evt_valid),
      .evt_key    (evt_key),
      .evt_down   (evt_down),
      .evt_ready  (evt_ready),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read on the next falling edge.
   task automatic send(input logic [7:0] b);
      code_valid = 1'b1;
      code       = b;
      @(negedge clk);
      code_valid = 1'b0;
      code       = 8'h00;
   endtask

   task automatic pop_expect(input string tag, input logic [4:0] k, input logic d);
      check({tag, "_valid"}, 32'(evt_valid), 32'd1);
      check({tag, "_key"},   32'(evt_key),   32'(k));
      check({tag, "_down"},  32'(evt_down),  32'(d));
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic drain(output int n);
      n = 0;
      evt_ready = 1'b1;
      for (int i = 0; i < 20 && evt_valid; i++) begin
         @(negedge clk);
         n++;
      end
      evt_ready = 1'b0;
      check("drain_bounded", 32'(evt_valid), 32'd0);
   endtask

   int n_evt;

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_matrix",   32'(key_matrix), 32'h0);
      check("rst_any",      32'(any_key),    32'd0);
      check("rst_valid",    32'(evt_valid),  32'd0);
      check("rst_key",      32'(evt_key),    32'd0);
      check("rst_down",     32'(evt_down),   32'd0);
      check("rst_overflow", 32'(overflow),   32'd0);
      check("rst_state",    32'(u_dut.state), 32'(ST_IDLE));
      res = 1'b1;
      @(negedge clk);

      // Make and break of key 2
      send(8'h1E);
      check("make_matrix", 32'(key_matrix), 32'h0004);
      check("make_any",    32'(any_key),    32'd1);
      pop_expect("make_evt", 5'd2, 1'b1);
      send(8'hF0);
      send(8'h1E);
      check("brk_matrix", 32'(key_matrix), 32'h0000);
      pop_expect("brk_evt", 5'd2, 1'b0);
      check("brk_empty", 32'(evt_valid), 32'd0);

      // Extended sequences are discarded
      send(8'h16);
      pop_expect("hold1_evt", 5'd1, 1'b1);
      send(8'hE0); send(8'h1E);
      send(8'hE0); send(8'hF0); send(8'h16);
      check("ext_matrix", 32'(key_matrix), 32'h0002);
      check("ext_noevt",  32'(evt_valid),  32'd0);
      check("ext_state",  32'(u_dut.state), 32'(ST_IDLE));
      send(8'hF0); send(8'h16);
      pop_expect("rel1_evt", 5'd1, 1'b0);

      // Unmapped code is ignored
      send(8'h55);
      check("unmapped_matrix", 32'(key_matrix), 32'h0);
      check("unmapped_noevt",  32'(evt_valid),  32'd0);

      // Overflow: five makes into a 4-deep FIFO
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h15);
      check("ovf_flag",   32'(overflow),   32'd1);
      check("ovf_count",  32'(u_dut.fifo_count), 32'd4);
      check("ovf_matrix", 32'(key_matrix), 32'h101E);
      pop_expect("ovf_pop0", 5'd1,  1'b1);
      pop_expect("ovf_pop1", 5'd2,  1'b1);
      pop_expect("ovf_pop2", 5'd3,  1'b1);
      pop_expect("ovf_pop3", 5'd12, 1'b1);
      check("ovf_empty",  32'(evt_valid), 32'd0);
      check("ovf_sticky", 32'(overflow),  32'd1);

      // AA clears the matrix without generating events
      send(8'hAA);
      check("bat_matrix", 32'(key_matrix), 32'h0);
      check("bat_noevt",  32'(evt_valid),  32'd0);

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_overflow", 32'(overflow),   32'd0);
      check("clr_matrix",   32'(key_matrix), 32'h0);

      // Simultaneous push and pop on a full FIFO
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      check("full_count", 32'(u_dut.fifo_count), 32'd4);
      code_valid = 1'b1;
      code       = 8'h15;
      evt_ready  = 1'b1;
      @(negedge clk);
      code_valid = 1'b0;
      evt_ready  = 1'b0;
      check("pp_overflow", 32'(overflow), 32'd0);
      check("pp_count",    32'(u_dut.fifo_count), 32'd4);
      pop_expect("pp_pop0", 5'd2,  1'b1);
      pop_expect("pp_pop1", 5'd3,  1'b1);
      pop_expect("pp_pop2", 5'd12, 1'b1);
      pop_expect("pp_pop3", 5'd4,  1'b1);
      check("pp_empty", 32'(evt_valid), 32'd0);

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;

      // Typematic repeat of key 0
      send(8'h22); send(8'h22); send(8'h22);
      check("typ_matrix", 32'(key_matrix), 32'h0001);
`ifdef KEYPAD_TYPEMATIC_FILTER_EN
      check("typ_count", 32'(u_dut.fifo_count), 32'd1);
`else
      check("typ_count", 32'(u_dut.fifo_count), 32'd3);
`endif
      drain(n_evt);
`ifdef KEYPAD_TYPEMATIC_FILTER_EN
      check("typ_events", 32'(n_evt), 32'd1);
`else
      check("typ_events", 32'(n_evt), 32'd3);
`endif

      // Reset in the middle of a break sequence
      send(8'hF0);
      res = 1'b0;
      @(negedge clk);
      check("midrst_matrix", 32'(key_matrix), 32'h0);
      check("midrst_valid",  32'(evt_valid),  32'd0);
      res = 1'b1;
      @(negedge clk);
      send(8'h1A);
      check("midrst_press", 32'(key_matrix), 32'h0400);
      pop_expect("midrst_evt", 5'd10, 1'b1);

      // clear wins over code_valid; fill FIFO first so the flush is visible
      send(8'h16); send(8'hF0);
      check("pre_clr_state", 32'(u_dut.state), 32'(ST_BRK));
      clear      = 1'b1;
      code_valid = 1'b1;
      code       = 8'h1A;
      @(negedge clk);
      clear      = 1'b0;
      code_valid = 1'b0;
      check("clrcv_matrix", 32'(key_matrix), 32'h0);
      check("clrcv_any",    32'(any_key),    32'd0);
      check("clrcv_valid",  32'(evt_valid),  32'd0);
      check("clrcv_key",    32'(evt_key),    32'd0);
      check("clrcv_ovf",    32'(overflow),   32'd0);
      check("clrcv_state",  32'(u_dut.state), 32'(ST_IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
